flash_region_programmer: RTL
============================

Name: flash_region_programmer

Overview:
- Sequencer above flash_state_machine. Turns one "program N pages at address A" request into a series of macro operations: 4 kB subsector erases (FlashERS4kB, 4'hA) interleaved with 256-byte page programs (FlashWrPg, 4'hC).
- Each page program waits for the UART page buffer to report a full page.
- Sits between the UART command decoder/page buffer and flash_state_machine's macro_states interface.

Parameters:
- TIMEOUT_CYCLES, 32'd50_000_000, max cycles from a macro_states_valid pulse to its macro_states_done before error.
- PAGE_BYTES, 256, page size; fixed. Address increment per page.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- start_addr  in  32  byte address of first page
- num_pages  in  16  pages to program
- abort  in  1  level; stop after the in-flight macro completes
- page_ready  in  1  page buffer holds ≥1 complete 256-byte page
- page_consume  out  1  1-cycle pulse: the page just programmed may be released
- macro_states  out  4  macro op code to flash_state_machine
- macro_states_valid  out  1  1-cycle request pulse
- macro_states_done  in  1  1-cycle completion pulse from flash_state_machine
- addr_out  out  64  {32'b0, op address}; stable from valid until done
- busy  out  1  high in any state except IDLE
- done  out  1  1-cycle pulse at end of sequence, success or not
- aborted  out  1  sticky until next accepted start
- err_code  out  2  0 none, 1 bad request, 2 timeout, 3 address overflow; sticky until next accepted start
- pages_done  out  16  count of completed page programs

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including macro_states=4'h0 and addr_out=0.
- States: IDLE, CHECK, ERS_REQ, ERS_WAIT, DATA_WAIT, PRG_REQ, PRG_WAIT, NEXT, FINISH.
- IDLE:
  - start=1 latches start_addr and num_pages.
  - Clears err_code, aborted and pages_done.
  - Sets cur_addr=start_addr, remaining=num_pages, need_erase=1. Goes to CHECK.
- CHECK, single cycle:
  - start_addr[7:0]≠0 or num_pages==0 → err_code=1 → FINISH.
  - Else 33-bit start_addr + num_pages*256 > 2^32 → err_code=3 → FINISH.
  - Else → ERS_REQ if need_erase, otherwise DATA_WAIT.
  - No valid is ever issued on an error path.
- ERS_REQ:
  - Drives macro_states=4'hA and addr_out={32'b0, cur_addr[31:12], 12'h000}.
  - Pulses valid for exactly 1 cycle, clears the timeout counter → ERS_WAIT.
- ERS_WAIT: on macro_states_done → need_erase=0 → DATA_WAIT.
- DATA_WAIT:
  - abort=1 → aborted=1 → FINISH.
  - Else if page_ready=1 → PRG_REQ. Waits indefinitely; no timeout here.
- PRG_REQ: macro_states=4'hC, addr_out={32'b0, cur_addr}, valid pulse 1 cycle, clear timeout counter → PRG_WAIT.
- PRG_WAIT: on done → page_consume=1 for that 1 cycle, pages_done+1, remaining−1, cur_addr+256 → NEXT.
- NEXT:
  - remaining==0 → FINISH.
  - Else abort=1 → aborted=1 → FINISH.
  - Else cur_addr[11:0]==0 → ERS_REQ (new subsector). Otherwise → DATA_WAIT.
- FINISH: done=1 for 1 cycle → IDLE. busy falls in the same cycle IDLE is entered.
- Timeout:
  - The counter runs only in ERS_WAIT/PRG_WAIT.
  - Reaching TIMEOUT_CYCLES without done → err_code=2 → FINISH, with no page_consume.
  - A done arriving in the same cycle the counter expires counts as success.
- Abort:
  - Never cancels an issued macro; flash_state_machine cannot be interrupted.
  - Checked only in DATA_WAIT and NEXT.
- Ignored inputs:
  - start while busy.
  - macro_states_done outside ERS_WAIT/PRG_WAIT (no state change).
  - page_ready outside DATA_WAIT.
- macro_states and addr_out hold their last value until the next request.
- Exactly one outstanding macro at a time; the next valid is never earlier than 2 cycles after the prior done.

Test Plan:
- start_addr=0x00001000, num_pages=2, page_ready=1, done 10 cycles after each valid → valid sequence (A,0x1000), (C,0x1000), (C,0x1100); 2 page_consume pulses; pages_done=2; done pulse; err_code=0.
- start_addr=0x00000F00, num_pages=2 → (A,0x0000), (C,0x0F00), (A,0x1000), (C,0x1000).
- start_addr=0x00000010 → err_code=1, done within 3 cycles, zero valid pulses. Repeat with num_pages=0 → err_code=1. Repeat with start_addr=0xFFFFFF00, num_pages=2 → err_code=3.
- TIMEOUT_CYCLES=100, done never asserted → err_code=2 and done ~101 cycles after the erase valid; busy=0 afterwards; next start accepted and clears err_code.
- abort raised during PRG_WAIT of page 1 of 4 → that program completes (page_consume=1, pages_done=1), no further valid, aborted=1, done pulse.
- page_ready held low 500 cycles in DATA_WAIT → no valid, no timeout; raise page_ready → PRG_REQ next cycle. Assert rst mid-PRG_WAIT → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/flash_region_programmer.sv
// Region programmer: turns one "program N pages at A" request into interleaved
// 4 kB subsector erases and 256-byte page programs issued to flash_state_machine.
module flash_region_programmer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
    parameter int          PAGE_BYTES     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic [15:0] num_pages,
    input  logic        abort,
    input  logic        page_ready,
    output logic        page_consume,
    output logic [3:0]  macro_states,
    output logic        macro_states_valid,
    input  logic        macro_states_done,
    output logic [63:0] addr_out,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [1:0]  err_code,
    output logic [15:0] pages_done
);

    // state     | meaning
    // IDLE      | waiting for start
    // CHECK     | validate alignment, length and address range
    // ERS_REQ   | 1-cycle erase request (valid high)
    // ERS_WAIT  | waiting for erase completion / timeout
    // DATA_WAIT | waiting for a full page in the buffer, or abort
    // PRG_REQ   | 1-cycle page program request (valid high)
    // PRG_WAIT  | waiting for program completion / timeout
    // NEXT      | decide: finish, abort, new subsector or next page
    // FINISH    | 1-cycle done pulse
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CHECK     = 4'd1;
    localparam logic [3:0] S_ERS_REQ   = 4'd2;
    localparam logic [3:0] S_ERS_WAIT  = 4'd3;
    localparam logic [3:0] S_DATA_WAIT = 4'd4;
    localparam logic [3:0] S_PRG_REQ   = 4'd5;
    localparam logic [3:0] S_PRG_WAIT  = 4'd6;
    localparam logic [3:0] S_NEXT      = 4'd7;
    localparam logic [3:0] S_FINISH    = 4'd8;

    localparam logic [3:0]  OP_ERS   = 4'hA;
    localparam logic [3:0]  OP_PRG   = 4'hC;
    localparam logic [1:0]  ERR_REQ  = 2'd1;
    localparam logic [1:0]  ERR_TMO  = 2'd2;
    localparam logic [1:0]  ERR_OVF  = 2'd3;
    localparam logic [31:0] PAGE_INC = 32'(PAGE_BYTES);

    logic [3:0]  state;
    logic [31:0] cur_addr;
    logic [31:0] op_addr;
    logic [15:0] remaining;
    logic        need_erase;
    logic [31:0] tmo_cnt;
    logic [32:0] end_addr;

    // 33-bit sum so a region ending exactly at 2^32 is still legal
    assign end_addr = {1'b0, cur_addr} + 33'(remaining) * 33'(PAGE_BYTES);

    assign busy               = (state != S_IDLE);
    assign done               = (state == S_FINISH);
    assign macro_states_valid = (state == S_ERS_REQ) || (state == S_PRG_REQ);
    assign page_consume       = (state == S_PRG_WAIT) && macro_states_done;
    assign addr_out           = {32'b0, op_addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cur_addr     <= '0;
            op_addr      <= '0;
            remaining    <= '0;
            need_erase   <= 1'b0;
            tmo_cnt      <= '0;
            macro_states <= 4'h0;
            aborted      <= 1'b0;
            err_code     <= 2'd0;
            pages_done   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_addr   <= start_addr;
                        remaining  <= num_pages;
                        need_erase <= 1'b1;
                        err_code   <= 2'd0;
                        aborted    <= 1'b0;
                        pages_done <= '0;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cur_addr[7:0] != 8'h00 || remaining == 16'd0) begin
                        err_code <= ERR_REQ;
                        state    <= S_FINISH;
                    end else if (end_addr > 33'h1_0000_0000) begin
                        err_code <= ERR_OVF;
                        state    <= S_FINISH;
                    end else if (need_erase) begin
                        macro_states <= OP_ERS;
                        op_addr      <= {cur_addr[31:12], 12'h000};
                        state        <= S_ERS_REQ;
                    end else begin
                        state <= S_DATA_WAIT;
                    end
                end
                S_ERS_REQ: begin
                    tmo_cnt <= TIMEOUT_CYCLES - 32'd1;
                    state   <= S_ERS_WAIT;
                end
                S_ERS_WAIT: begin
                    if (macro_states_done) begin
                        need_erase <= 1'b0;
                        state      <= S_DATA_WAIT;
                    end else if (tmo_cnt == 32'd0) begin
                        err_code <= ERR_TMO;
                        state    <= S_FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt - 32'd1;
                    end
                end
                S_DATA_WAIT: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= S_FINISH;
                    end else if (page_ready) begin
                        macro_states <= OP_PRG;
                        op_addr      <= cur_addr;
                        state        <= S_PRG_REQ;
                    end
                end
                S_PRG_REQ: begin
                    tmo_cnt <= TIMEOUT_CYCLES - 32'd1;
                    state   <= S_PRG_WAIT;
                end
                S_PRG_WAIT: begin
                    // done wins over a simultaneous timeout expiry
                    if (macro_states_done) begin
                        pages_done <= pages_done + 16'd1;
                        remaining  <= remaining - 16'd1;
                        cur_addr   <= cur_addr + PAGE_INC;
                        state      <= S_NEXT;
                    end else if (tmo_cnt == 32'd0) begin
                        err_code <= ERR_TMO;
                        state    <= S_FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt - 32'd1;
                    end
                end
                S_NEXT: begin
                    if (remaining == 16'd0) begin
                        state <= S_FINISH;
                    end else if (abort) begin
                        aborted <= 1'b1;
                        state   <= S_FINISH;
                    end else if (cur_addr[11:0] == 12'h000) begin
                        macro_states <= OP_ERS;
                        op_addr      <= {cur_addr[31:12], 12'h000};
                        state        <= S_ERS_REQ;
                    end else begin
                        state <= S_DATA_WAIT;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule
